snn_config_bank: RTL and testbench
==================================

Name: snn_config_bank

Overview:
- Parametrised successor to the fixed-slice configuration map of the SNN top level.
- Receives an already-synchronised SPI byte stream and assembles it into a shadow byte array through a small command protocol.
- Copies the shadow array atomically into an active array on commit.
- Emits per-region update pulses that replace the separate clk_div/input_spike/debug ready synchronizer paths.

Parameters:
- NUM_BYTES, 224, configuration bytes held; must be 8 to 256.
- SPIKE_BYTES, 3, bytes [0, SPIKE_BYTES) form the input-spike region.
- DIV_ADDR, 6, address of the clock-divider byte.
- DEBUG_ADDR, 223, address of the debug-config byte; must be less than NUM_BYTES.
- ADDR_W, 8, address counter width; must satisfy 2^ADDR_W >= NUM_BYTES.

Ports:
- system_clock  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle pulse: SS asserted, already synchronised.
- frame_end  in  1  one-cycle pulse: SS deasserted, already synchronised.
- rx_byte  in  8  received byte.
- rx_valid  in  1  rx_byte valid this cycle.
- rx_ready  out  1  byte accepted when rx_valid && rx_ready.
- active_data  out  NUM_BYTES*8  committed configuration; byte k is bits [8k+7:8k].
- commit_pulse  out  1  one cycle, on every commit.
- spike_update  out  1  one cycle, at a commit where the spike region was written.
- clk_div_update  out  1  one cycle, at a commit where DIV_ADDR was written.
- debug_update  out  1  one cycle, at a commit where DEBUG_ADDR was written.
- overflow  out  1  sticky: a write was dropped past NUM_BYTES-1.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (sync, active-high) clears:
  - shadow array, active_data, dirty flags, address counter, command register;
  - all pulse outputs, overflow, busy;
  - state to IDLE.
- rx_ready resets to 1.
- Reset mid-frame or mid-commit discards everything; no commit_pulse is produced.
- FSM states: IDLE, CMD, ADDR, DATA, COMMIT.
- IDLE:
  - frame_start -> CMD.
  - rx_valid bytes are accepted and ignored.
- CMD:
  - The accepted byte latches op = rx_byte[7:6]: 00 WRITE, 01 COMMIT, 10 WRITE_COMMIT, 11 NOP.
  - WRITE/WRITE_COMMIT -> ADDR; COMMIT/NOP -> DATA, with writes disabled.
- ADDR:
  - The accepted byte loads the address counter with rx_byte[ADDR_W-1:0] -> DATA.
- DATA, each accepted byte when writes are enabled:
  - address < NUM_BYTES: write shadow[address] and set the matching dirty flag(s).
  - otherwise: drop the byte and set overflow.
  - Address increments by 1 after every accepted byte and saturates at its maximum; no wrap.
- frame_end in CMD/ADDR/DATA:
  - op COMMIT or WRITE_COMMIT, with frame_end sampled at edge E: state = COMMIT from E.
    - At E+1, active_data <= shadow.
    - commit_pulse is high for the cycle following E+1.
    - Each region update pulse is high in that same cycle only if its dirty flag is set.
    - All dirty flags are then cleared -> IDLE.
  - Any other op -> IDLE; shadow is kept and dirty flags persist.
- rx_ready = 0 only in COMMIT. The sender must hold rx_valid, and no byte is lost.
- Byte and frame_end in the same cycle: the byte is processed first, then frame_end.
- frame_start in any non-COMMIT state aborts the current frame -> CMD.
  - Shadow writes already made are retained.
- frame_start during COMMIT: the commit completes, then the FSM goes to CMD.
- frame_start and frame_end in the same cycle: frame_start wins and frame_end is ignored.
- overflow clears only on reset.
- active_data never changes except at commit or reset.

Optional Feature:
- SNN_CFG_READBACK_EN defined:
  - Adds output port tx_byte [7:0], registered and driven 1 cycle after each accepted byte in DATA.
  - tx_byte = active byte at the current address, or 0x00 if the address is >= NUM_BYTES.
  - COMMIT/NOP frames thus read from address 0 onward for the MISO path.
- Not defined: the port is absent and no readback mux is built.

Test Plan:
- Reset, then frame: 0x00, 0x06, 0x05, then frame_end -> shadow[6] = 0x05; active_data all 0; no pulses; busy returns to 0.
- Frame 0x40 (COMMIT) then frame_end -> 2 cycles later active byte 6 = 0x05; commit_pulse = 1 for one cycle; clk_div_update = 1; spike_update = 0; debug_update = 0.
- WRITE_COMMIT 0x80, addr 0x00, bytes 0xAA 0xBB 0xCC -> active bytes 0..2 = AA BB CC; spike_update = 1; rx_ready = 0 for exactly one cycle.
- WRITE at addr 0xDE (NUM_BYTES=224) with 3 bytes -> bytes 222 and 223 written; third byte dropped; overflow = 1; debug_update fires on the next commit.
- frame_start mid-DATA, then new frame 0xC0 (NOP) -> earlier bytes remain in shadow; no commit; active unchanged.
- Reset asserted one cycle into COMMIT -> no commit_pulse; active_data = 0; state IDLE.

Source files
------------

// File: rtl/snn_config_bank.sv
// SPI-fed configuration bank: command/address/data framing into a shadow array, atomic commit to active.
// Optional MISO readback port tx_byte is built when SNN_CFG_READBACK_EN is defined.
module snn_config_bank #(
    parameter int NUM_BYTES   = 224,
    parameter int SPIKE_BYTES = 3,
    parameter int DIV_ADDR    = 6,
    parameter int DEBUG_ADDR  = 223,
    parameter int ADDR_W      = 8
) (
    input  logic                   system_clock,
    input  logic                   reset,
    input  logic                   frame_start,
    input  logic                   frame_end,
    input  logic [7:0]             rx_byte,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    output logic [NUM_BYTES*8-1:0] active_data,
    output logic                   commit_pulse,
    output logic                   spike_update,
    output logic                   clk_div_update,
    output logic                   debug_update,
    output logic                   overflow,
    output logic                   busy
`ifdef SNN_CFG_READBACK_EN
    ,
    output logic [7:0]             tx_byte
`endif
);

    localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_COMMIT} state_t;
    typedef enum logic [1:0] {
        OP_WRITE        = 2'b00,
        OP_COMMIT       = 2'b01,
        OP_WRITE_COMMIT = 2'b10,
        OP_NOP          = 2'b11
    } op_t;

    state_t            r_state;
    state_t            w_state_next;
    op_t               r_op;
    op_t               w_op_eff;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_rx_addr;
    logic [IDX_W-1:0]  w_idx;
    logic [7:0]        r_shadow [NUM_BYTES];
    logic [7:0]        r_active [NUM_BYTES];
    logic              r_dirty_spike;
    logic              r_dirty_div;
    logic              r_dirty_dbg;
    logic              r_commit_pulse;
    logic              r_spike_update;
    logic              r_div_update;
    logic              r_dbg_update;
    logic              r_overflow;
    logic              w_accept;
    logic              w_take;
    logic              w_commit_op;
    logic              w_write_en;
    logic              w_in_range;
    logic              w_hit_spike;
    logic              w_hit_div;
    logic              w_hit_dbg;

    assign w_accept    = rx_valid && rx_ready;
    // frame_start aborts the frame, so a byte arriving with it is not processed
    assign w_take      = w_accept && !frame_start;
    assign w_rx_addr   = ADDR_W'(rx_byte);
    assign w_idx       = r_addr[IDX_W-1:0];
    assign w_in_range  = int'(r_addr) < NUM_BYTES;
    assign w_hit_spike = int'(r_addr) < SPIKE_BYTES;
    assign w_hit_div   = int'(r_addr) == DIV_ADDR;
    assign w_hit_dbg   = int'(r_addr) == DEBUG_ADDR;
    assign w_write_en  = (r_op == OP_WRITE) || (r_op == OP_WRITE_COMMIT);
    // a command byte arriving together with frame_end decides the frame's fate
    assign w_op_eff    = (r_state == S_CMD && w_take) ? op_t'(rx_byte[7:6]) : r_op;
    assign w_commit_op = (w_op_eff == OP_COMMIT) || (w_op_eff == OP_WRITE_COMMIT);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (frame_start) w_state_next = S_CMD;
            end
            S_CMD, S_ADDR, S_DATA: begin
                if (frame_start) begin
                    w_state_next = S_CMD;
                end else if (frame_end) begin
                    w_state_next = w_commit_op ? S_COMMIT : S_IDLE;
                end else if (w_take) begin
                    if (r_state == S_CMD) begin
                        w_state_next = ((w_op_eff == OP_WRITE) || (w_op_eff == OP_WRITE_COMMIT))
                                       ? S_ADDR : S_DATA;
                    end else if (r_state == S_ADDR) begin
                        w_state_next = S_DATA;
                    end
                end
            end
            S_COMMIT: begin
                w_state_next = frame_start ? S_CMD : S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge system_clock) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_op           <= OP_WRITE;
            r_addr         <= '0;
            r_shadow       <= '{default: '0};
            r_active       <= '{default: '0};
            r_dirty_spike  <= 1'b0;
            r_dirty_div    <= 1'b0;
            r_dirty_dbg    <= 1'b0;
            r_commit_pulse <= 1'b0;
            r_spike_update <= 1'b0;
            r_div_update   <= 1'b0;
            r_dbg_update   <= 1'b0;
            r_overflow     <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_commit_pulse <= 1'b0;
            r_spike_update <= 1'b0;
            r_div_update   <= 1'b0;
            r_dbg_update   <= 1'b0;

            if (frame_start) begin
                r_op <= OP_NOP;
            end else begin
                case (r_state)
                    S_CMD: begin
                        if (w_take) begin
                            r_op <= op_t'(rx_byte[7:6]);
                            if (rx_byte[7:6] == OP_COMMIT || rx_byte[7:6] == OP_NOP) r_addr <= '0;
                        end
                    end
                    S_ADDR: begin
                        if (w_take) r_addr <= w_rx_addr;
                    end
                    S_DATA: begin
                        if (w_take) begin
                            if (w_write_en) begin
                                if (w_in_range) begin
                                    r_shadow[w_idx] <= rx_byte;
                                    if (w_hit_spike) r_dirty_spike <= 1'b1;
                                    if (w_hit_div)   r_dirty_div   <= 1'b1;
                                    if (w_hit_dbg)   r_dirty_dbg   <= 1'b1;
                                end else begin
                                    r_overflow <= 1'b1;
                                end
                            end
                            if (r_addr != '1) r_addr <= r_addr + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

            if (r_state == S_COMMIT) begin
                r_active       <= r_shadow;
                r_commit_pulse <= 1'b1;
                r_spike_update <= r_dirty_spike;
                r_div_update   <= r_dirty_div;
                r_dbg_update   <= r_dirty_dbg;
                r_dirty_spike  <= 1'b0;
                r_dirty_div    <= 1'b0;
                r_dirty_dbg    <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NUM_BYTES; g++) begin : g_active
        assign active_data[g*8 +: 8] = r_active[g];
    end

`ifdef SNN_CFG_READBACK_EN
    logic [7:0] r_tx_byte;

    always_ff @(posedge system_clock) begin
        if (reset) begin
            r_tx_byte <= '0;
        end else if (r_state == S_DATA && w_take) begin
            r_tx_byte <= w_in_range ? r_active[w_idx] : 8'h00;
        end
    end

    assign tx_byte = r_tx_byte;
`endif

    assign rx_ready       = (r_state != S_COMMIT);
    assign busy           = (r_state != S_IDLE);
    assign commit_pulse   = r_commit_pulse;
    assign spike_update   = r_spike_update;
    assign clk_div_update = r_div_update;
    assign debug_update   = r_dbg_update;
    assign overflow       = r_overflow;

endmodule

// File: tb/tb_snn_config_bank.sv
// Scoreboard bench for snn_config_bank: expected commits are queued when frames end, checked on commit_pulse.
module tb_snn_config_bank;

    localparam int NB = 224;

    logic            system_clock = 1'b0;
    logic            reset;
    logic            frame_start;
    logic            frame_end;
    logic [7:0]      rx_byte;
    logic            rx_valid;
    logic            rx_ready;
    logic [NB*8-1:0] active_data;
    logic            commit_pulse;
    logic            spike_update;
    logic            clk_div_update;
    logic            debug_update;
    logic            overflow;
    logic            busy;
`ifdef SNN_CFG_READBACK_EN
    logic [7:0]      tx_byte;
`endif

    snn_config_bank #(
        .NUM_BYTES  (NB),
        .SPIKE_BYTES(3),
        .DIV_ADDR   (6),
        .DEBUG_ADDR (223),
        .ADDR_W     (8)
    ) dut (
        .system_clock  (system_clock),
        .reset         (reset),
        .frame_start   (frame_start),
        .frame_end     (frame_end),
        .rx_byte       (rx_byte),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .active_data   (active_data),
        .commit_pulse  (commit_pulse),
        .spike_update  (spike_update),
        .clk_div_update(clk_div_update),
        .debug_update  (debug_update),
        .overflow      (overflow),
        .busy          (busy)
`ifdef SNN_CFG_READBACK_EN
        ,
        .tx_byte       (tx_byte)
`endif
    );

    always #5 system_clock = ~system_clock;

    typedef struct packed {
        logic [NB*8-1:0] data;
        logic            spike;
        logic            div;
        logic            dbg;
    } exp_t;

    exp_t sb_q[$];
    exp_t e_pop;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model of the shadow side of the bank
    logic [7:0] m_shadow [NB];
    bit         m_dsp, m_ddiv, m_ddbg, m_ovf;
    int         m_phase;   // 0 idle, 1 cmd, 2 addr, 3 data
    logic [1:0] m_op;
    int         m_addr;

    function automatic logic [7:0] get_byte(input logic [NB*8-1:0] v, input int idx);
        logic [NB*8-1:0] t;
        t = v >> (8 * idx);
        return t[7:0];
    endfunction

    function automatic logic [NB*8-1:0] pack_shadow();
        logic [NB*8-1:0] r;
        r = '0;
        for (int i = 0; i < NB; i++) r = r | ({{(NB*8-8){1'b0}}, m_shadow[i]} << (8 * i));
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NB; i++) m_shadow[i] = 8'h00;
        m_dsp = 0; m_ddiv = 0; m_ddbg = 0; m_ovf = 0;
        m_phase = 0; m_op = 2'b00; m_addr = 0;
        sb_q.delete();
    endtask

    task automatic model_byte(input logic [7:0] b);
        case (m_phase)
            1: begin
                m_op = b[7:6];
                if (m_op == 2'b00 || m_op == 2'b10) m_phase = 2;
                else begin m_phase = 3; m_addr = 0; end
            end
            2: begin m_addr = int'(b); m_phase = 3; end
            3: begin
                if (m_op == 2'b00 || m_op == 2'b10) begin
                    if (m_addr < NB) begin
                        m_shadow[m_addr] = b;
                        if (m_addr < 3)   m_dsp  = 1;
                        if (m_addr == 6)  m_ddiv = 1;
                        if (m_addr == 223) m_ddbg = 1;
                    end else begin
                        m_ovf = 1;
                    end
                end
                if (m_addr < 255) m_addr++;
            end
            default: ;
        endcase
    endtask

    task automatic model_end();
        exp_t e;
        if (m_phase != 0 && (m_op == 2'b01 || m_op == 2'b10)) begin
            e.data = pack_shadow(); e.spike = m_dsp; e.div = m_ddiv; e.dbg = m_ddbg;
            sb_q.push_back(e);
            m_dsp = 0; m_ddiv = 0; m_ddbg = 0;
        end
        m_phase = 0;
    endtask

    task automatic tick();
        @(posedge system_clock);
        #1;
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        m_phase = 1; m_op = 2'b11;
    endtask

    task automatic end_frame();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        model_end();
    endtask

    task automatic send_byte(input logic [7:0] b, input bit with_end);
        int waited = 0;
        rx_byte  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        if (waited >= 20) check("rx_ready_timeout", 0, 1);
        frame_end = with_end;
        tick();
        rx_valid  = 1'b0;
        frame_end = 1'b0;
        model_byte(b);
        if (with_end) model_end();
    endtask

    // Commit monitor: pops one expectation per commit_pulse and guards active_data stability
    logic [NB*8-1:0] prev_active = '0;
    bit              rst_at_edge = 1'b0;

    always @(posedge system_clock) rst_at_edge = reset;

    initial begin
        forever begin
            @(negedge system_clock);
            if (commit_pulse === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("commit_unexpected", 1, 0);
                end else begin
                    e_pop = sb_q.pop_front();
                    check("spike_update", 32'(spike_update), 32'(e_pop.spike));
                    check("clk_div_update", 32'(clk_div_update), 32'(e_pop.div));
                    check("debug_update", 32'(debug_update), 32'(e_pop.dbg));
                    for (int i = 0; i < NB; i++)
                        check($sformatf("active_b%0d", i), 32'(get_byte(active_data, i)),
                              32'(get_byte(e_pop.data, i)));
                end
            end else begin
                if ({spike_update, clk_div_update, debug_update} !== 3'b000)
                    check("stray_pulse", 32'({spike_update, clk_div_update, debug_update}), 0);
                if (active_data !== prev_active && !rst_at_edge)
                    check("active_stable", 0, 1);
            end
            prev_active = active_data;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; frame_start = 1'b0; frame_end = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
        model_reset();
        tick(); tick();
        reset = 1'b0;
        check("rst_busy", 32'(busy), 0);
        check("rst_rx_ready", 32'(rx_ready), 1);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_commit_pulse", 32'(commit_pulse), 0);
        check("rst_active_zero", 32'(active_data === '0), 1);

        // plain write, no commit
        start_frame();
        check("busy_in_frame", 32'(busy), 1);
        send_byte(8'h00, 0); send_byte(8'h06, 0); send_byte(8'h05, 0);
        end_frame();
        check("busy_after_write", 32'(busy), 0);
        check("b6_uncommitted", 32'(get_byte(active_data, 6)), 0);

        // commit only: div region dirty
        start_frame();
        send_byte(8'h40, 0);
        end_frame();
        check("rx_ready_in_commit", 32'(rx_ready), 0);
        check("busy_in_commit", 32'(busy), 1);
        tick();
        check("rx_ready_after_commit", 32'(rx_ready), 1);
        check("busy_after_commit", 32'(busy), 0);
        check("b6_committed", 32'(get_byte(active_data, 6)), 32'h05);
        tick();

        // write+commit into spike region
        start_frame();
        send_byte(8'h80, 0); send_byte(8'h00, 0);
        send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'hCC, 0);
        end_frame();
        tick(); tick();

        // write past the end of the array
        start_frame();
        send_byte(8'h00, 0); send_byte(8'hDE, 0);
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
        end_frame();
        check("overflow_set", 32'(overflow), 32'(m_ovf));
        start_frame();
        send_byte(8'h40, 0);
        end_frame();
        tick(); tick();
        check("overflow_sticky", 32'(overflow), 1);

        // abort mid-data, then NOP frame
        start_frame();
        send_byte(8'h00, 0); send_byte(8'h10, 0); send_byte(8'h77, 0);
        start_frame();
        send_byte(8'hC0, 0);
        end_frame();
        tick(); tick();
        check("b16_not_active", 32'(get_byte(active_data, 16)), 0);
        start_frame();
        send_byte(8'h40, 0);
        end_frame();
        tick(); tick();

        // reset one cycle into COMMIT
        start_frame();
        send_byte(8'h80, 0); send_byte(8'h01, 0); send_byte(8'h99, 0);
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        tick();
        check("rstc_active_zero", 32'(active_data === '0), 1);
        check("rstc_busy", 32'(busy), 0);
        check("rstc_overflow", 32'(overflow), 0);
        start_frame();
        send_byte(8'h40, 0);
        end_frame();
        tick(); tick();

        // last data byte together with frame_end
        start_frame();
        send_byte(8'h80, 0); send_byte(8'h02, 0);
        send_byte(8'h5A, 1);
        tick(); tick();

        // frame_start and frame_end together: end ignored
        start_frame();
        send_byte(8'h80, 0); send_byte(8'h07, 0); send_byte(8'h66, 0);
        frame_start = 1'b1; frame_end = 1'b1;
        tick();
        frame_start = 1'b0; frame_end = 1'b0;
        m_phase = 1; m_op = 2'b11;
        end_frame();
        tick(); tick();
        check("b7_not_active", 32'(get_byte(active_data, 7)), 0);

        repeat (3) tick();
        check("sb_drain", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
